// File: rtl/mcu_io_pkg.sv
// Shared definitions for the MCU I/O interrupt controller: FSM states and I/O port map.
package mcu_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int         MAX_SRC   = 8;
    localparam logic [7:0] MASK_PORT = 8'h20;
    localparam logic [7:0] PEND_PORT = 8'h21;
    localparam logic [7:0] ID_PORT   = 8'h22;

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: two-flop synchroniser followed by a rising-edge detector.
module irq_edge_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic IRQ,
    output logic RISE
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= IRQ;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign RISE = sync2_reg & ~prev_reg;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt source side of the MCU handshake: pending/mask registers, fixed-priority
// winner selection, REQ/HOLD handshake FSM and the IN-port read mux.
module interrupt_controller
    import mcu_io_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               INT_ACK,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic [7:0]         IN_DATA,
    output logic               INT
);

    localparam logic [MAX_SRC-1:0] SRC_EN = 8'((9'd1 << NUM_SRC) - 9'd1);

    function automatic logic [2:0] lowest_set(input logic [MAX_SRC-1:0] v);
        logic [2:0] res;
        res = 3'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) res = 3'(i);
        end
        return res;
    endfunction

    logic [MAX_SRC-1:0] rise;
    logic [MAX_SRC-1:0] mask_reg;
    logic [MAX_SRC-1:0] pending_reg;
    logic [MAX_SRC-1:0] pending_next;
    logic [MAX_SRC-1:0] clr_bits;
    logic [MAX_SRC-1:0] active;
    logic [2:0]         winner;
    logic [2:0]         winner_reg;
    logic [2:0]         id_reg;
    logic               valid_reg;
    logic               int_reg;
    logic               req;
    logic               ack_take;
    logic               wr_mask;
    logic               wr_pend;
    logic               wr_id;
    state_t             state_reg;
    state_t             state_next;

    generate
        for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_used
                irq_edge_sync u_sync (
                    .CLK     (CLK),
                    .RESET_N (RESET_N),
                    .IRQ     (IRQ_IN[gi]),
                    .RISE    (rise[gi])
                );
            end else begin : g_unused
                assign rise[gi] = 1'b0;
            end
        end
    endgenerate

    assign wr_mask = IO_STRB && (PORT_ID == MASK_PORT);
    assign wr_pend = IO_STRB && (PORT_ID == PEND_PORT);
    assign wr_id   = IO_STRB && (PORT_ID == ID_PORT);

    assign active = pending_reg & mask_reg;
    assign req    = |active;
    assign winner = lowest_set(active);

    always_comb begin
        state_next = state_reg;
        ack_take   = 1'b0;
        case (state_reg)
            IDLE: if (req) state_next = REQ;
            REQ: begin
                // An ack is honoured even if the request vanished this same cycle.
                if (INT_ACK) begin
                    ack_take   = 1'b1;
                    state_next = HOLD;
                end else if (!req) begin
                    state_next = IDLE;
                end
            end
            HOLD:    state_next = req ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clr_bits = wr_pend ? OUT_PORT : 8'h00;
        if (ack_take) clr_bits = clr_bits | (8'd1 << winner_reg);
        // A fresh rise outranks any clear on the same bit.
        pending_next = ((pending_reg & ~clr_bits) | rise) & SRC_EN;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= IDLE;
            int_reg     <= 1'b0;
            mask_reg    <= '0;
            pending_reg <= '0;
            winner_reg  <= 3'd0;
            id_reg      <= 3'd0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            int_reg     <= (state_next == REQ);
            pending_reg <= pending_next;
            if (wr_mask) mask_reg <= OUT_PORT & SRC_EN;
            if (req) winner_reg <= winner;
            if (ack_take) begin
                id_reg    <= winner_reg;
                valid_reg <= 1'b1;
            end else if (wr_id) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign INT = int_reg;

    always_comb begin
        IN_DATA = 8'h00;
        case (PORT_ID)
            MASK_PORT: IN_DATA = mask_reg;
            PEND_PORT: IN_DATA = pending_reg;
            ID_PORT:   IN_DATA = {valid_reg, 4'b0000, id_reg};
            default:   IN_DATA = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: register-access vector table plus
// hand-written handshake sequences, with reads checked through a scoreboard queue.
module tb_interrupt_controller;
    import mcu_io_pkg::*;

    logic       CLK      = 1'b0;
    logic       RESET_N  = 1'b1;
    logic [7:0] IRQ_IN   = 8'hFF;
    logic       INT_ACK  = 1'b0;
    logic [7:0] PORT_ID  = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB  = 1'b0;
    logic [7:0] IN_DATA;
    logic       INT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic       do_wr;
        logic [7:0] wr_port;
        logic [7:0] wr_data;
        logic [7:0] rd_port;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[7];

    interrupt_controller #(.NUM_SRC(8)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IRQ_IN   (IRQ_IN),
        .INT_ACK  (INT_ACK),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .IN_DATA  (IN_DATA),
        .INT      (INT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end else begin
            $display("ok   %s: %02h", name, act);
        end
    endtask

    task automatic chk_int(input string name, input logic exp);
        chk(name, {7'b0, INT}, {7'b0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] data);
        PORT_ID  = port;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        @(posedge CLK);
        #1;
        IO_STRB  = 1'b0;
        OUT_PORT = 8'h00;
        PORT_ID  = 8'h00;
    endtask

    task automatic rd(input string name, input logic [7:0] port, input logic [7:0] exp);
        sb_t e;
        PORT_ID = port;
        e.name  = name;
        e.exp   = exp;
        sb_q.push_back(e);
        @(negedge CLK);
        e = sb_q.pop_front();
        chk(e.name, IN_DATA, e.exp);
        PORT_ID = 8'h00;
    endtask

    task automatic ack;
        INT_ACK = 1'b1;
        step(1);
        INT_ACK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, PEND_PORT, 8'h0F, PEND_PORT, 8'hF0};
        tbl[1] = '{1'b1, PEND_PORT, 8'hF0, PEND_PORT, 8'h00};
        tbl[2] = '{1'b1, MASK_PORT, 8'h5A, MASK_PORT, 8'h5A};
        tbl[3] = '{1'b1, MASK_PORT, 8'h00, MASK_PORT, 8'h00};
        tbl[4] = '{1'b1, 8'h23,     8'hFF, MASK_PORT, 8'h00};
        tbl[5] = '{1'b0, 8'h00,     8'h00, 8'h23,     8'h00};
        tbl[6] = '{1'b1, ID_PORT,   8'h55, ID_PORT,   8'h00};

        // Reset with all lines high
        #2 RESET_N = 1'b0;
        step(2);
        chk_int("rst_int", 1'b0);
        rd("rst_mask", MASK_PORT, 8'h00);
        rd("rst_pend", PEND_PORT, 8'h00);
        rd("rst_id",   ID_PORT,   8'h00);
        RESET_N = 1'b1;
        step(4);
        chk_int("rel_int_masked", 1'b0);
        rd("rel_pend", PEND_PORT, 8'hFF);
        rd("rel_mask", MASK_PORT, 8'h00);
        IRQ_IN = 8'h00;

        // Register access vectors
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_wr) io_out(tbl[i].wr_port, tbl[i].wr_data);
            rd($sformatf("vec%0d_rd", i), tbl[i].rd_port, tbl[i].exp);
            chk_int($sformatf("vec%0d_int", i), 1'b0);
        end

        // Basic handshake and 4-cycle latency
        io_out(MASK_PORT, 8'h04);
        IRQ_IN = 8'h04;
        step(3);
        chk_int("basic_int_lat3", 1'b0);
        step(1);
        chk_int("basic_int_lat4", 1'b1);
        ack();
        chk_int("basic_int_hold", 1'b0);
        rd("basic_id",   ID_PORT,   8'h82);
        rd("basic_pend", PEND_PORT, 8'h00);
        step(1);
        chk_int("basic_int_idle", 1'b0);

        // Fixed priority between two simultaneous sources
        IRQ_IN = 8'h00;
        step(3);
        io_out(MASK_PORT, 8'hFF);
        IRQ_IN = 8'h22;
        step(4);
        chk_int("prio_int", 1'b1);
        ack();
        chk_int("prio_hold", 1'b0);
        rd("prio_id1", ID_PORT, 8'h81);
        step(1);
        chk_int("prio_reassert", 1'b1);
        ack();
        chk_int("prio_hold2", 1'b0);
        rd("prio_id2", ID_PORT, 8'h85);
        step(1);
        chk_int("prio_idle", 1'b0);
        rd("prio_pend", PEND_PORT, 8'h00);

        // Withdraw a request by clearing it, then a stray ack
        IRQ_IN = 8'h00;
        step(3);
        IRQ_IN = 8'h08;
        step(4);
        chk_int("wd_int", 1'b1);
        io_out(PEND_PORT, 8'h08);
        step(1);
        chk_int("wd_dropped", 1'b0);
        ack();
        chk_int("stray_ack_int", 1'b0);
        rd("stray_ack_id",   ID_PORT,   8'h85);
        rd("stray_ack_pend", PEND_PORT, 8'h00);
        step(2);
        chk_int("stray_ack_idle", 1'b0);

        // W1C colliding with a synchronised rise on the same bit
        IRQ_IN = 8'h00;
        step(3);
        IRQ_IN = 8'h01;
        step(2);
        io_out(PEND_PORT, 8'h01);
        rd("coll_w1c_pend", PEND_PORT, 8'h01);
        step(1);
        chk_int("coll_int", 1'b1);
        // Ack colliding with a new rise on the winner
        IRQ_IN = 8'h00;
        step(3);
        IRQ_IN = 8'h01;
        step(2);
        ack();
        chk_int("coll_ack_hold", 1'b0);
        rd("coll_ack_pend", PEND_PORT, 8'h01);
        rd("coll_ack_id",   ID_PORT,   8'h80);
        step(1);
        chk_int("coll_reassert", 1'b1);
        ack();
        rd("coll_final_pend", PEND_PORT, 8'h00);
        io_out(ID_PORT, 8'h00);
        rd("id_write_clears_valid", ID_PORT, 8'h00);

        // Asynchronous reset while requesting
        IRQ_IN = 8'h00;
        step(3);
        IRQ_IN = 8'h10;
        step(4);
        chk_int("areset_pre_int", 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        chk_int("areset_int_async", 1'b0);
        rd("areset_mask", MASK_PORT, 8'h00);
        rd("areset_pend", PEND_PORT, 8'h00);
        rd("areset_id",   ID_PORT,   8'h00);
        IRQ_IN  = 8'h00;
        RESET_N = 1'b1;
        step(3);
        chk_int("areset_after", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
